// File: rtl/lc3_io_pkg.sv
// Shared LC-3 memory-mapped I/O definitions.
// Contents: receiver state encodings, KBSR bit positions, device addresses,
// the KBSR word layout and a helper that widens a byte into a KBDR word.
package lc3_io_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_CLEANUP = 3'd4
    } rx_state_e;

    localparam int unsigned KBSR_READY = 15;
    localparam int unsigned KBSR_IE    = 14;
    localparam int unsigned KBSR_OVR   = 13;
    localparam int unsigned KBSR_FRM   = 12;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;

    // KBSR layout as seen by the datapath.
    typedef struct packed {
        logic        ready;
        logic        ie;
        logic        ovr;
        logic        frm;
        logic [11:0] rsvd;
    } kbsr_t;

    function automatic logic [WORD_W-1:0] kbdr_word(input logic [DATA_W-1:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, framing FSM, LSB-first shift register.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   rx           raw serial line, idle high, asynchronous to clk
//   rx_byte      last assembled byte (valid when byte_valid pulses)
//   byte_valid   one-cycle pulse: good stop bit seen, rx_byte ready to commit
//   frame_err    one-cycle pulse: stop bit sampled low, byte discarded
module uart_rx
    import lc3_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic              rx_m;
    logic              rx_s;
    rx_state_e         state;
    rx_state_e         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift;

    logic cnt_clr_c;
    logic cnt_inc_c;
    logic sample_bit_c;
    logic commit_c;
    logic ferr_c;

    // Two-flop synchronizer; idle-high reset so a held-high line never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RX_IDLE:    if (!rx_s) state_nxt = RX_START;
            RX_START:   if (cnt == HALF_CNT) state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:    if (cnt == LAST_CNT && bit_idx == 3'd7) state_nxt = RX_STOP;
            RX_STOP:    if (cnt == LAST_CNT) state_nxt = RX_CLEANUP;
            RX_CLEANUP: state_nxt = RX_IDLE;
            default:    state_nxt = RX_IDLE;
        endcase
    end

    // Datapath control strobes; every sample point also restarts the bit timer.
    always_comb begin
        cnt_clr_c    = 1'b0;
        cnt_inc_c    = 1'b0;
        sample_bit_c = 1'b0;
        commit_c     = 1'b0;
        ferr_c       = 1'b0;
        unique case (state)
            RX_IDLE: cnt_clr_c = 1'b1;
            RX_START: begin
                if (cnt == HALF_CNT) cnt_clr_c = 1'b1;
                else                 cnt_inc_c = 1'b1;
            end
            RX_DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_clr_c    = 1'b1;
                    sample_bit_c = 1'b1;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_clr_c = 1'b1;
                    commit_c  = rx_s;
                    ferr_c    = ~rx_s;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            RX_CLEANUP: cnt_clr_c = 1'b1;
            default:    cnt_clr_c = 1'b1;
        endcase
    end

    // Bit timer, bit index, shift register and result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= commit_c;
            frame_err  <= ferr_c;
            if (cnt_clr_c)      cnt <= '0;
            else if (cnt_inc_c) cnt <= cnt + CNT_W'(1);
            if (state == RX_IDLE) begin
                bit_idx <= 3'd0;
            end else if (sample_bit_c) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

    assign rx_byte = shift;

endmodule

// File: rtl/kbd_input.sv
// LC-3 keyboard input stage: serial receiver feeding the KBDR/KBSR device registers.
// Ports:
//   i_Clk, reset_   clock and asynchronous active-low reset
//   i_rx            raw serial input (RsRx)
//   rd_kbdr         datapath has read KBDR (clears ready)
//   ld_kbsr         CPU write of KBSR with kbsr_in
//   kbsr_in         write data; bit 14 sets ie, bits 13/12 are write-0-to-clear for ovr/frm
//   kbdr            {8'h00, last received byte}
//   kbsr            {ready, ie, ovr, frm, 12'h000}
//   o_rx_dv         one-cycle pulse when a byte lands in KBDR
//   intr            ready & ie
module kbd_input
    import lc3_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        i_Clk,
    input  logic        reset_,
    input  logic        i_rx,
    input  logic        rd_kbdr,
    input  logic        ld_kbsr,
    input  logic [15:0] kbsr_in,
    output logic [15:0] kbdr,
    output logic [15:0] kbsr,
    output logic        o_rx_dv,
    output logic        intr
);

    logic [DATA_W-1:0] rx_byte;
    logic              byte_valid;
    logic              frame_err;

    logic [DATA_W-1:0] data_q;
    logic              ready;
    logic              ie;
    logic              ovr;
    logic              frm;
    logic              rx_dv_q;
    kbsr_t             kbsr_w;
    logic              unused_kbsr_in;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (i_Clk),
        .rst_n      (reset_),
        .rx         (i_rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Device registers. A commit outranks a same-cycle read, and hardware sets of ovr/frm
    // outrank a same-cycle software clear.
    always_ff @(posedge i_Clk or negedge reset_) begin
        if (!reset_) begin
            data_q  <= '0;
            ready   <= 1'b0;
            ie      <= 1'b0;
            ovr     <= 1'b0;
            frm     <= 1'b0;
            rx_dv_q <= 1'b0;
        end else begin
            rx_dv_q <= byte_valid;
            if (byte_valid)   data_q <= rx_byte;
            if (byte_valid)   ready  <= 1'b1;
            else if (rd_kbdr) ready  <= 1'b0;
            if (ld_kbsr)      ie     <= kbsr_in[KBSR_IE];
            ovr <= (byte_valid & ready & ~rd_kbdr)
                 | (ld_kbsr ? (ovr & kbsr_in[KBSR_OVR]) : ovr);
            frm <= frame_err
                 | (ld_kbsr ? (frm & kbsr_in[KBSR_FRM]) : frm);
        end
    end

    // KBSR word assembly.
    always_comb begin
        kbsr_w       = '0;
        kbsr_w.ready = ready;
        kbsr_w.ie    = ie;
        kbsr_w.ovr   = ovr;
        kbsr_w.frm   = frm;
    end

    // Read-only and reserved bits of a KBSR write have no effect.
    assign unused_kbsr_in = ^{kbsr_in[KBSR_READY], kbsr_in[11:0]};

    assign kbdr    = kbdr_word(data_q);
    assign kbsr    = kbsr_w;
    assign o_rx_dv = rx_dv_q;
    assign intr    = ready & ie;

endmodule

// File: tb/tb_kbd_input.sv
// Self-checking bench for kbd_input: directed scenarios plus randomized frames/strobes,
// checked against a register-level model of KBDR/KBSR.
module tb_kbd_input;

    localparam int unsigned CPB = 8;
    localparam int unsigned FRAME_CYC = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        rd = 1'b0;
    logic        ld = 1'b0;
    logic [15:0] kin = 16'h0000;
    logic [15:0] kbdr;
    logic [15:0] kbsr;
    logic        dv;
    logic        intr;

    kbd_input #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk   (clk),
        .reset_  (rst_n),
        .i_rx    (rx),
        .rd_kbdr (rd),
        .ld_kbsr (ld),
        .kbsr_in (kin),
        .kbdr    (kbdr),
        .kbsr    (kbsr),
        .o_rx_dv (dv),
        .intr    (intr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-level model.
    logic [7:0] m_data = 8'h00;
    bit m_ready = 0, m_ie = 0, m_ovr = 0, m_frm = 0;
    logic [7:0] exp_q[$];
    int unsigned start_cyc = 0;
    int unsigned lat = 0;
    int dv_count = 0;
    int exp_dv = 0;
    bit prev_dv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_kbsr();
        return {m_ready, m_ie, m_ovr, m_frm, 12'h000};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) step();
    endtask

    task automatic snapshot(input string name);
        chk({name, "_kbdr"}, kbdr, {8'h00, m_data});
        chk({name, "_kbsr"}, kbsr, m_kbsr());
        chk({name, "_intr"}, intr, m_ready & m_ie);
    endtask

    task automatic do_rd();
        rd = 1'b1;
        step();
        rd = 1'b0;
        m_ready = 0;
    endtask

    task automatic do_ld(input logic [15:0] v);
        ld = 1'b1;
        kin = v;
        step();
        ld = 1'b0;
        m_ie  = v[14];
        m_ovr = m_ovr & v[13];
        m_frm = m_frm & v[12];
    endtask

    // Drive one 8N1 frame plus a short high tail; optionally pulse rd_kbdr so it
    // coincides with the commit edge rd_at cycles after the start edge.
    task automatic send_frame(input logic [7:0] b, input bit good, input int rd_at);
        logic [9:0] bits;
        bits = {good, b, 1'b0};
        if (good) begin
            exp_q.push_back(b);
            exp_dv++;
        end
        start_cyc = cyc;
        for (int k = 0; k < int'(FRAME_CYC) + 4; k++) begin
            rx = (k < int'(FRAME_CYC)) ? bits[k / int'(CPB)] : 1'b1;
            rd = (rd_at > 0 && k == rd_at - 1);
            step();
        end
        rd = 1'b0;
        if (good) begin
            if (rd_at <= 0) m_ovr = m_ovr | m_ready;
            m_ready = 1;
            m_data  = b;
        end else begin
            m_frm = 1;
            idle(2 * CPB);
        end
    endtask

    // Per-cycle checks of the output relationships and of each commit pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("kbdr_hi_zero", kbdr[15:8], 8'h00);
            chk("kbsr_rsvd_zero", kbsr[11:0], 12'h000);
            chk("intr_rule", intr, kbsr[15] & kbsr[14]);
            if (dv) begin
                dv_count++;
                chk("dv_width", prev_dv, 1'b0);
                chk("dv_ready", kbsr[15], 1'b1);
                if (lat == 0) lat = cyc - start_cyc;
                if (exp_q.size() == 0) begin
                    chk("dv_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("dv_byte", kbdr[7:0], exp_q.pop_front());
                end
            end
            prev_dv = dv;
        end else begin
            prev_dv = 0;
        end
    end

    initial begin
        #(50000 * 10);
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int dv_before;
        logic [7:0] b;
        bit good;
        int op;

        // Reset values.
        repeat (3) step();
        chk("rst_kbdr", kbdr, 16'h0000);
        chk("rst_kbsr", kbsr, 16'h0000);
        chk("rst_dv", dv, 1'b0);
        chk("rst_intr", intr, 1'b0);
        rst_n = 1'b1;
        idle(4);

        // Single good byte.
        send_frame(8'h41, 1, 0);
        chk("f41_kbdr", kbdr, 16'h0041);
        chk("f41_kbsr", kbsr, 16'h8000);
        chk("f41_intr", intr, 1'b0);
        chk("f41_dv_count", dv_count, 1);
        chk("latency_lo", lat >= 9 * CPB, 1'b1);
        chk("latency_hi", lat <= 11 * CPB, 1'b1);
        snapshot("f41");
        do_rd();
        chk("rd1_kbsr", kbsr, 16'h0000);

        // Interrupt enable, then read.
        do_ld(16'h4000);
        send_frame(8'h0D, 1, 0);
        chk("ie_kbsr", kbsr, 16'hC000);
        chk("ie_intr", intr, 1'b1);
        do_rd();
        chk("ie_rd_kbsr", kbsr, 16'h4000);
        chk("ie_rd_intr", intr, 1'b0);
        do_ld(16'h0000);

        // Overrun.
        send_frame(8'h31, 1, 0);
        idle(2);
        send_frame(8'h32, 1, 0);
        chk("ovr_kbdr", kbdr, 16'h0032);
        chk("ovr_kbsr", kbsr, 16'hA000);
        do_ld(16'h0000);
        chk("ovr_clr_kbsr", kbsr, 16'h8000);
        snapshot("ovr");

        // Framing error, then recovery.
        send_frame(8'h55, 0, 0);
        chk("frm_kbdr", kbdr, 16'h0032);
        chk("frm_bit", kbsr[12], 1'b1);
        snapshot("frm");
        send_frame(8'hAA, 1, 0);
        chk("frm_next_kbdr", kbdr, 16'h00AA);
        snapshot("frm_next");

        // Start-bit glitch.
        dv_before = dv_count;
        rx = 1'b0;
        repeat (3) step();
        idle(3 * CPB);
        chk("glitch_no_dv", dv_count, dv_before);
        snapshot("glitch");

        // Read strobe in the exact commit cycle, with ready already set.
        do_ld(16'h0000);
        chk("pre_sim_kbsr", kbsr, 16'h8000);
        send_frame(8'h5A, 1, int'(lat));
        chk("sim_kbsr", kbsr, 16'h8000);
        chk("sim_kbdr", kbdr, 16'h005A);
        snapshot("sim");

        // Reset during bit 4 of 8'hFF.
        rx = 1'b0;
        repeat (CPB) step();
        rx = 1'b1;
        repeat (4 * CPB + CPB / 2) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_kbdr", kbdr, 16'h0000);
        chk("mid_rst_kbsr", kbsr, 16'h0000);
        repeat (3) step();
        rst_n = 1'b1;
        m_data = 8'h00; m_ready = 0; m_ie = 0; m_ovr = 0; m_frm = 0;
        idle(3 * CPB);
        chk("post_rst_kbdr", kbdr, 16'h0000);
        chk("post_rst_kbsr", kbsr, 16'h0000);
        send_frame(8'h7E, 1, 0);
        chk("post_rst_7e", kbdr, 16'h007E);
        snapshot("post_rst");

        // Randomized frames and strobes.
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send_frame(b, good, 0);
            op = $urandom_range(0, 2);
            if (op == 1) do_rd();
            else if (op == 2) do_ld(16'($urandom));
            idle($urandom_range(1, CPB));
            snapshot("rand");
        end

        idle(2 * CPB);
        chk("queue_empty", exp_q.size(), 0);
        chk("dv_total", dv_count, exp_dv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
